// File: rtl/afe_pulser_mc_if.sv
// afe_pulser_mc_if: trigger, per-channel configuration and serialiser-word bundle for afe_pulser_mc
interface afe_pulser_mc_if #(
  parameter int N_CH  = 4,
  parameter int SER_W = 6,
  parameter int CNT_W = 16
);
  logic                    trig;
  logic [N_CH-1:0]         ch_en;
  logic [N_CH-1:0]         y0;
  logic [N_CH*CNT_W-1:0]   width;
  logic [N_CH*CNT_W-1:0]   delay;
  logic [N_CH*CNT_W-1:0]   period;
  logic [N_CH*CNT_W-1:0]   n_pulses;
  logic [N_CH*SER_W-1:0]   out_word;
  logic [N_CH-1:0]         busy;
  logic                    done;
  modport master (output trig, ch_en, y0, width, delay, period, n_pulses, input out_word, busy, done);
  modport slave  (input trig, ch_en, y0, width, delay, period, n_pulses, output out_word, busy, done);
endinterface

// File: rtl/afe_pulser_mc.sv
// afe_pulser_mc: multi-channel triggered pulser producing OSERDES words, bit 0 first.
// Define AFE_PULSER_BURST_EN to enable multi-pulse bursts via period/n_pulses.
module afe_pulser_mc #(
  parameter int N_CH  = 4,
  parameter int SER_W = 6,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  afe_pulser_mc_if.slave bus
);
`ifdef AFE_PULSER_BURST_EN
  typedef enum logic [1:0] {IDLE, DELAY, FIRE, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DELAY, FIRE} state_t;
  logic unused_cfg;
  assign unused_cfg = ^{bus.period, bus.n_pulses};
`endif
  logic            trig_q;
  logic            go;
  logic [N_CH-1:0] busy_q;
  assign go = bus.trig & ~trig_q & ~|bus.busy;
  assign bus.done = |busy_q & ~|bus.busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b1;
      busy_q <= '0;
    end else begin
      trig_q <= bus.trig;
      busy_q <= bus.busy;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           st, st_n;
    logic [CNT_W-1:0] w_i, d_i, rem, rem_n, dcnt, dcnt_n, wid_l;
    logic [SER_W:0]   one_sh;
    logic [SER_W-1:0] raw, raw_q;
    logic             fire_q, last, acc;
    assign w_i  = bus.width[i*CNT_W +: CNT_W];
    assign d_i  = bus.delay[i*CNT_W +: CNT_W];
    assign acc  = go & bus.ch_en[i] & (st == IDLE);
    assign last = rem <= CNT_W'(SER_W);
    // rem is at most SER_W whenever the partial mask is used
    assign one_sh = (SER_W+1)'(1) << rem;
    assign raw = (st == FIRE) ? (last ? SER_W'(one_sh - (SER_W+1)'(1)) : '1) : '0;
    assign bus.out_word[i*SER_W +: SER_W] = raw_q ^ {SER_W{bus.y0[i]}};
    assign bus.busy[i] = (st != IDLE) | fire_q;
`ifdef AFE_PULSER_BURST_EN
    logic [CNT_W-1:0] p_i, n_i, per_l, pcnt, pcnt_n, npl, npl_n;
    assign p_i = bus.period[i*CNT_W +: CNT_W];
    assign n_i = bus.n_pulses[i*CNT_W +: CNT_W];
`endif
    always_comb begin
      st_n   = st;
      rem_n  = last ? '0 : rem - CNT_W'(SER_W);
      dcnt_n = dcnt - CNT_W'(dcnt != '0);
`ifdef AFE_PULSER_BURST_EN
      pcnt_n = pcnt - CNT_W'(pcnt != '0);
      npl_n  = npl;
`endif
      case (st)
        IDLE: if (acc) begin
          st_n   = (d_i != '0) ? DELAY : FIRE;
          rem_n  = w_i;
          dcnt_n = d_i;
`ifdef AFE_PULSER_BURST_EN
          pcnt_n = p_i;
          npl_n  = (n_i == '0) ? CNT_W'(1) : n_i;
`endif
        end
        DELAY: if (dcnt <= CNT_W'(1)) begin
          st_n  = FIRE;
          rem_n = wid_l;
`ifdef AFE_PULSER_BURST_EN
          pcnt_n = per_l;
`endif
        end
        FIRE: if (last) begin
`ifdef AFE_PULSER_BURST_EN
          // pcnt counts down from period since this pulse started; short periods chain back-to-back
          st_n  = (npl > CNT_W'(1)) ? ((pcnt <= CNT_W'(1)) ? FIRE : GAP) : IDLE;
          npl_n = npl - CNT_W'(npl != '0);
          if (npl > CNT_W'(1) && pcnt <= CNT_W'(1)) begin
            rem_n  = wid_l;
            pcnt_n = per_l;
          end
`else
          st_n = IDLE;
`endif
        end
`ifdef AFE_PULSER_BURST_EN
        GAP: if (pcnt <= CNT_W'(1)) begin
          st_n   = FIRE;
          rem_n  = wid_l;
          pcnt_n = per_l;
        end
`endif
        default: st_n = IDLE;
      endcase
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        st     <= IDLE;
        rem    <= '0;
        dcnt   <= '0;
        wid_l  <= '0;
        raw_q  <= '0;
        fire_q <= 1'b0;
`ifdef AFE_PULSER_BURST_EN
        pcnt   <= '0;
        npl    <= '0;
        per_l  <= '0;
`endif
      end else begin
        st     <= st_n;
        rem    <= rem_n;
        dcnt   <= dcnt_n;
        wid_l  <= acc ? w_i : wid_l;
        raw_q  <= raw;
        fire_q <= st == FIRE;
`ifdef AFE_PULSER_BURST_EN
        pcnt   <= pcnt_n;
        npl    <= npl_n;
        per_l  <= acc ? p_i : per_l;
`endif
      end
    end
  end
endmodule

// File: tb/tb_afe_pulser_mc.sv
// tb_afe_pulser_mc: directed stimulus with a queue scoreboard checking output words and done timing
module tb_afe_pulser_mc;
  localparam int N = 4, S = 6, C = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  afe_pulser_mc_if #(.N_CH(N), .SER_W(S), .CNT_W(C)) bus();
  afe_pulser_mc #(.N_CH(N), .SER_W(S), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int cyc; logic [S-1:0] w;} ev_t;
  ev_t exp_q[N][$];
  int  done_q[$];
  int  cyc = 0, checks = 0, failures = 0, k = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h required 0x%0h", name, cyc, act, req);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(int ch, bit en, bit y, int w, int d, int p, int n);
    bus.ch_en[ch] = en;
    bus.y0[ch] = y;
    bus.width[ch*C +: C] = C'(w);
    bus.delay[ch*C +: C] = C'(d);
    bus.period[ch*C +: C] = C'(p);
    bus.n_pulses[ch*C +: C] = C'(n);
  endtask
  task automatic push(int ch, int c, logic [S-1:0] w);
    ev_t e;
    e.cyc = c;
    e.w = w;
    exp_q[ch].push_back(e);
  endtask
  task automatic fire();
    step();
    bus.trig = 1'b1;
    k = cyc;
    step();
    bus.trig = 1'b0;
  endtask
  task automatic settle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.busy == '0;
    end
    chk("settle_timeout", int'(ok), 1);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cyc >= 2) begin
      for (int ch = 0; ch < N; ch++) begin
        logic [S-1:0] w;
        ev_t e;
        w = bus.out_word[ch*S +: S];
        if (w !== {S{bus.y0[ch]}}) begin
          if (exp_q[ch].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word ch%0d at cycle %0d: got 0x%0h required idle", ch, cyc, w);
          end else begin
            e = exp_q[ch].pop_front();
            chk($sformatf("word_cycle_ch%0d", ch), cyc, e.cyc);
            chk($sformatf("word_value_ch%0d", ch), int'(w), int'(e.w));
          end
        end
      end
      if (bus.done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done at cycle %0d: got 1 required 0", cyc);
        end else chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    int left;
    bus.trig = 1'b0;
    bus.ch_en = '0;
    bus.y0 = 4'b0010;
    bus.width = '0;
    bus.delay = '0;
    bus.period = '0;
    bus.n_pulses = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_word", int'(bus.out_word), 'h000FC0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    bus.y0 = '0;
    // width 14: two full words then three bits; a re-trigger while busy is ignored
    cfg(0, 1, 0, 14, 0, 0, 0);
    fire();
    push(0, k+2, 6'h3F); push(0, k+3, 6'h3F); push(0, k+4, 6'h03);
    done_q.push_back(k+5);
    @(negedge clk) chk("busy_k1", int'(bus.busy), 1);
    step(); bus.trig = 1'b1;
    step(); bus.trig = 1'b0;
    step(); @(negedge clk) chk("busy_k4", int'(bus.busy), 1);
    step(); @(negedge clk) chk("busy_k5", int'(bus.busy), 0);
    settle();
    cfg(0, 1, 0, 6, 0, 0, 0);
    fire();
    push(0, k+2, 6'h3F);
    done_q.push_back(k+3);
    settle();
    // width 7; inputs changed after the trigger must not disturb the sequence
    cfg(0, 1, 0, 7, 0, 0, 0);
    fire();
    push(0, k+2, 6'h3F); push(0, k+3, 6'h01);
    done_q.push_back(k+4);
    cfg(0, 1, 0, 60, 5, 0, 0);
    settle();
    cfg(0, 1, 1, 3, 0, 0, 0);
    step();
    @(negedge clk) chk("idle_active_low_before", int'(bus.out_word[5:0]), 'h3F);
    fire();
    push(0, k+2, 6'h38);
    done_q.push_back(k+3);
    step(); step();
    @(negedge clk) chk("idle_active_low_after", int'(bus.out_word[5:0]), 'h3F);
    settle();
    cfg(0, 1, 0, 1, 0, 0, 0);
    cfg(1, 1, 0, 1, 3, 0, 0);
    fire();
    push(0, k+2, 6'h01); push(1, k+5, 6'h01);
    done_q.push_back(k+6);
    settle();
    cfg(1, 0, 0, 0, 0, 0, 0);
    cfg(0, 0, 0, 5, 0, 0, 0);
    fire();
    @(negedge clk) chk("disabled_busy", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    // width 0 still occupies one FIRE cycle after the delay
    cfg(0, 1, 0, 0, 2, 0, 0);
    fire();
    done_q.push_back(k+5);
    @(negedge clk) chk("zero_width_busy", int'(bus.busy), 1);
    settle();
    cfg(0, 1, 0, 6, 0, 4, 3);
    fire();
`ifdef AFE_PULSER_BURST_EN
    push(0, k+2, 6'h3F); push(0, k+6, 6'h3F); push(0, k+10, 6'h3F);
    done_q.push_back(k+11);
    settle();
    cfg(0, 1, 0, 6, 0, 0, 3);
    fire();
    push(0, k+2, 6'h3F); push(0, k+3, 6'h3F); push(0, k+4, 6'h3F);
    done_q.push_back(k+5);
`else
    push(0, k+2, 6'h3F);
    done_q.push_back(k+3);
`endif
    settle();
    // reset during a long pulse aborts with no done
    cfg(0, 1, 0, 60, 0, 0, 0);
    fire();
    push(0, k+2, 6'h3F); push(0, k+3, 6'h3F); push(0, k+4, 6'h3F);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_out_word", int'(bus.out_word), 0);
    repeat (4) @(negedge clk);
    left = 0;
    for (int c = 0; c < N; c++) left += exp_q[c].size();
    chk("words_outstanding", left, 0);
    chk("dones_outstanding", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/afe_pulser_mc.md
AFE_PULSER_MC -- requirements
Module: afe_pulser_mc

Interface
REQ-001 Parameter N_CH, default 4, number of independent pulser channels sharing one trigger.
REQ-002 Parameter SER_W, default 6, serialisation factor (fast ticks per clk cycle, bits per output word).
REQ-003 Parameter CNT_W, default 16, width of the width, delay, period and burst-count fields.
REQ-004 clk  in  1  word-rate clock (clk_div of the external OSERDES); all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 trig  in  1  level trigger; a low-to-high transition starts a sequence.
REQ-007 ch_en  in  N_CH  per-channel enable, sampled at trigger.
REQ-008 y0  in  N_CH  per-channel idle level.
REQ-009 width  in  N_CH*CNT_W  per-channel pulse width in fast ticks.
REQ-010 delay  in  N_CH*CNT_W  per-channel start delay in clk cycles.
REQ-011 period  in  N_CH*CNT_W  per-channel pulse-start-to-pulse-start spacing in clk cycles (burst mode).
REQ-012 n_pulses  in  N_CH*CNT_W  per-channel pulse count (burst mode).
REQ-013 out_word  out  N_CH*SER_W  per-channel OSERDES words, bit 0 transmitted first.
REQ-014 busy  out  N_CH  channel sequence in progress.
REQ-015 done  out  1  single-cycle pulse when the last busy channel returns to idle.

Function
REQ-016 Trigger edge detected as trig=1 in cycle k with trig=0 in k-1; edge in reset-exit cycle ignored.
REQ-017 At the edge each enabled, idle channel latches width, delay, period, n_pulses; later input changes have no effect until that channel is idle.
REQ-018 Edges while any channel is busy are ignored for all channels.
REQ-019 Per-channel FSM states: IDLE, DELAY, FIRE, GAP; any undefined encoding returns to IDLE.
REQ-020 IDLE->DELAY on accepted edge if delay>0, else IDLE->FIRE; DELAY counts delay clk cycles then enters FIRE.
REQ-021 With delay=0, first FIRE word appears on out_word in cycle k+2; each delay unit adds one cycle.
REQ-022 FIRE emits all-ones words while remaining width > SER_W, decrementing by SER_W; the final word has the low (remaining) bits set, remaining in 1..SER_W.
REQ-023 width=0: no bits set, but FIRE still occupies one cycle and sequence timing is unchanged.
REQ-024 Raw word XORed with {SER_W{y0[i]}}, so y0=1 yields an active-low pulse; y0 applied live, idle word = {SER_W{y0[i]}}.
REQ-025 out_word registered; channels not in FIRE output all-zero raw words.
REQ-026 Counters are CNT_W-bit unsigned; no wrap-around, decrement saturates at zero.
REQ-027 busy[i] high from cycle k+1 until the cycle after the channel's final FIRE word.
REQ-028 done asserts for one cycle when busy transitions from nonzero to zero; simultaneous channel finishes give one done.
REQ-029 Disabled channels or no enabled channels: edge ignored for them, no busy, no done.

Reset
REQ-030 rst forces all FSMs to IDLE, counters to zero, raw words to zero, busy=0, done=0, edge-detector history=1.
REQ-031 rst mid-sequence aborts immediately; out_word = {SER_W{y0[i]}} the following cycle.

Configuration
REQ-032 Macro AFE_PULSER_BURST_EN enables bursting: after FIRE, if pulses remaining >1, enter GAP, and the next FIRE starts period cycles after the previous FIRE start.
REQ-033 With AFE_PULSER_BURST_EN, period smaller than pulse length in cycles is clamped: next FIRE starts the cycle after the previous one ends; n_pulses=0 treated as 1.
REQ-034 Without AFE_PULSER_BURST_EN, period and n_pulses are ignored, GAP does not exist, exactly one pulse per trigger.

Verification
REQ-035 SER_W=6, ch0 width=14, delay=0, y0=0, trig rises at k -> words 0x3F,0x3F,0x03 in cycles k+2..k+4, busy[0] k+1..k+4, done at k+5.
REQ-036 width=6 and width=7 -> single 0x3F word; 0x3F then 0x01 respectively.
REQ-037 y0=1, width=3 -> idle 0x3F, single word 0x38, then 0x3F.
REQ-038 ch0 delay=0, ch1 delay=3, both width=1 -> ch1 word 0x01 three cycles after ch0; one done after ch1.
REQ-039 Burst build: width=6, period=4, n_pulses=3 -> 0x3F at k+2, k+6, k+10; period=0 -> 0x3F at k+2, k+3, k+4.
REQ-040 Second trig edge while busy -> ignored; rst asserted mid-FIRE -> idle word next cycle, busy=0, no done.
